// File: rtl/clz_norm_arbiter.sv
// clz_norm_arbiter
// Shares one 128-bit count-leading-zeros / normalize datapath between NREQ
// requesters. A round-robin arbiter picks one requester per cycle. A
// two-stage pipeline returns the leading-zero count, the left-normalized
// operand and the ID of the requester that issued it.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   io_in_valid[NREQ]   per-requester operand valid
//   io_in_ready[NREQ]   per-requester accept (one-hot or zero)
//   io_in_data          packed operands, requester i at [128*i +: 128]
//   io_out_valid/ready  result handshake
//   io_out_id           requester index of the result
//   io_out_clz          leading-zero count (all-zero operand reports 127)
//   io_out_zero         operand was all zeros
//   io_out_norm         operand shifted left by io_out_clz
module clz_norm_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      io_in_valid,
  output logic [NREQ-1:0]      io_in_ready,
  input  logic [NREQ*128-1:0]  io_in_data,
  output logic                 io_out_valid,
  input  logic                 io_out_ready,
  output logic [IDW-1:0]       io_out_id,
  output logic [6:0]           io_out_clz,
  output logic                 io_out_zero,
  output logic [127:0]         io_out_norm
);

  localparam int DATA_W = 128;
  localparam int CLZ_W  = 7;

  // Binary-search CLZ in steps 64..1; returns {count, normalized operand}.
  // An all-zero operand falls through every step and reports 127 with a
  // zero mantissa, matching the existing CLZ128 convention.
  function automatic logic [CLZ_W+DATA_W-1:0] clz_norm(input logic [DATA_W-1:0] op);
    logic [DATA_W-1:0] x;
    logic [CLZ_W-1:0]  n;
    x = op;
    n = '0;
    for (int s = 6; s >= 0; s--) begin
      if ((x >> (DATA_W - (1 << s))) == '0) begin
        n = n | CLZ_W'(1 << s);
        x = x << (1 << s);
      end
    end
    return {n, x};
  endfunction

  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    gnt_idx;
  logic [IDW-1:0]    scan_idx;
  logic              any_grant;
  logic              adv1;
  logic              adv2;
  logic              in_accept;
  logic [DATA_W-1:0] op_sel;

  logic              vld_p1;
  logic [IDW-1:0]    id_p1;
  logic [DATA_W-1:0] data_p1;

  logic              vld_p2;
  logic [IDW-1:0]    id_p2;
  logic [CLZ_W-1:0]  clz_p2;
  logic              zero_p2;
  logic [DATA_W-1:0] norm_p2;

  assign adv2 = !vld_p2 || io_out_ready;
  assign adv1 = !vld_p1 || adv2;

  // Round-robin scan starting just after the last granted requester.
  always_comb begin
    any_grant = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = IDW'((int'(ptr) + k) % NREQ);
      if (!any_grant && io_in_valid[scan_idx]) begin
        any_grant = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  assign in_accept = any_grant && adv1 && !reset;
  assign op_sel    = io_in_data[int'(gnt_idx)*DATA_W +: DATA_W];

  always_comb begin
    io_in_ready = '0;
    if (in_accept) io_in_ready[gnt_idx] = 1'b1;
  end

  // Control state: pointer and stage valids.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr    <= IDW'(NREQ - 1);
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv1)      vld_p1 <= any_grant;
      if (adv2)      vld_p2 <= vld_p1;
      if (in_accept) ptr    <= gnt_idx;
    end
  end

  // Stage 1: capture granted operand and its ID
  always_ff @(posedge clock) begin
    if (adv1) begin
      id_p1   <= gnt_idx;
      data_p1 <= op_sel;
    end
  end

  // Stage 2: CLZ / normalize result, held while the consumer stalls
  always_ff @(posedge clock) begin
    if (reset) begin
      id_p2   <= '0;
      clz_p2  <= '0;
      zero_p2 <= 1'b0;
      norm_p2 <= '0;
    end else if (adv2 && vld_p1) begin
      {clz_p2, norm_p2} <= clz_norm(data_p1);
      zero_p2           <= (data_p1 == '0);
      id_p2             <= id_p1;
    end
  end

  assign io_out_valid = vld_p2;
  assign io_out_id    = id_p2;
  assign io_out_clz   = clz_p2;
  assign io_out_zero  = zero_p2;
  assign io_out_norm  = norm_p2;

endmodule

// File: tb/tb_clz_norm_arbiter.sv
// Testbench for clz_norm_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// queue-based reference model.
module tb_clz_norm_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     io_in_valid = '0;
  logic [NREQ-1:0]     io_in_ready;
  logic [NREQ*128-1:0] io_in_data = '0;
  logic                io_out_valid;
  logic                io_out_ready = 1'b1;
  logic [IDW-1:0]      io_out_id;
  logic [6:0]          io_out_clz;
  logic                io_out_zero;
  logic [127:0]        io_out_norm;

  clz_norm_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_data   (io_in_data),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_id    (io_out_id),
    .io_out_clz   (io_out_clz),
    .io_out_zero  (io_out_zero),
    .io_out_norm  (io_out_norm)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [IDW-1:0] id;
    logic [127:0]   op;
    int             t;
  } ent_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [6:0]     clz;
    logic           zero;
    logic [127:0]   norm;
    int             t;
  } out_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   mptr  = NREQ - 1;
  ent_t mq[$];
  ent_t acc_log[$];
  out_t out_log[$];

  logic           hold = 1'b0;
  logic [IDW-1:0] prev_id;
  logic [6:0]     prev_clz;
  logic           prev_zero;
  logic [127:0]   prev_norm;

  // Leading zeros counted directly from the MSB; all-zero reports 127.
  function automatic int ref_clz(input logic [127:0] op);
    int n;
    n = 0;
    while (n < 127 && !op[127-n]) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input int i, input logic [127:0] v);
    io_in_data[i*128 +: 128] = v;
  endtask

  task automatic drain();
    io_in_valid  = '0;
    io_out_ready = 1'b1;
    repeat (4) step();
  endtask

  function automatic logic [127:0] rnd_op();
    logic [127:0] v;
    int r;
    v = {$urandom, $urandom, $urandom, $urandom};
    r = $urandom_range(0, 15);
    if (r == 0) return '0;
    if (r == 1) return 128'd1;
    return v >> $urandom_range(0, 127);
  endfunction

  // Reference model and per-cycle comparison, sampled mid-cycle.
  always @(negedge clock) begin
    logic [NREQ-1:0] exp_rdy;
    logic            exp_ov;
    logic            found;
    int              win;
    int              idx;
    ent_t            e;
    out_t            o;
    cyc++;
    exp_rdy = '0;
    found   = 1'b0;
    win     = 0;
    if (!reset) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (mptr + k) % NREQ;
        if (!found && io_in_valid[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
      if (found && (mq.size() < 2 || io_out_ready)) exp_rdy[win] = 1'b1;
    end
    chk("in_ready", 128'(io_in_ready), 128'(exp_rdy));

    exp_ov = 1'b0;
    if (mq.size() > 0) begin
      if (mq[0].t + 2 <= cyc) exp_ov = 1'b1;
    end
    chk("out_valid", 128'(io_out_valid), 128'(exp_ov));

    if (hold) begin
      chk("stall_id",   128'(io_out_id),   128'(prev_id));
      chk("stall_clz",  128'(io_out_clz),  128'(prev_clz));
      chk("stall_zero", 128'(io_out_zero), 128'(prev_zero));
      chk("stall_norm", io_out_norm, prev_norm);
    end
    hold      = io_out_valid && !io_out_ready && !reset;
    prev_id   = io_out_id;
    prev_clz  = io_out_clz;
    prev_zero = io_out_zero;
    prev_norm = io_out_norm;

    if (reset) begin
      mq.delete();
      mptr = NREQ - 1;
    end else begin
      if (exp_ov && io_out_ready) begin
        e = mq.pop_front();
        chk("out_id",   128'(io_out_id),   128'(e.id));
        chk("out_clz",  128'(io_out_clz),  128'(ref_clz(e.op)));
        chk("out_zero", 128'(io_out_zero), 128'(e.op == '0));
        chk("out_norm", io_out_norm, e.op << ref_clz(e.op));
        o.id   = io_out_id;
        o.clz  = io_out_clz;
        o.zero = io_out_zero;
        o.norm = io_out_norm;
        o.t    = cyc;
        out_log.push_back(o);
      end
      if (exp_rdy != '0) begin
        e.id = IDW'(win);
        e.op = io_in_data[win*128 +: 128];
        e.t  = cyc;
        mq.push_back(e);
        acc_log.push_back(e);
        mptr = win;
      end
    end
  end

  initial begin
    // Reset state with every requester asking.
    io_in_valid = '1;
    step();
    chk("rst_valid", 128'(io_out_valid), 128'(0));
    chk("rst_id",    128'(io_out_id),    128'(0));
    chk("rst_clz",   128'(io_out_clz),   128'(0));
    chk("rst_zero",  128'(io_out_zero),  128'(0));
    chk("rst_norm",  io_out_norm,        128'(0));
    chk("rst_ready", 128'(io_in_ready),  128'(0));
    chk("model_pin", 128'(ref_clz(128'h0000_0000_0000_0001_0000_0000_0000_0000)), 128'(63));
    io_in_valid = '0;
    step();
    reset = 1'b0;
    step();

    // Single request from requester 2.
    acc_log.delete(); out_log.delete();
    io_in_valid = 4'b0100;
    set_op(2, 128'h0000_0000_0000_0001_0000_0000_0000_0000);
    step();
    drain();
    chk("t1_count", 128'(out_log.size()), 128'(1));
    if (out_log.size() >= 1 && acc_log.size() >= 1) begin
      chk("t1_id",   128'(out_log[0].id),   128'(2));
      chk("t1_clz",  128'(out_log[0].clz),  128'(63));
      chk("t1_zero", 128'(out_log[0].zero), 128'(0));
      chk("t1_norm", out_log[0].norm, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
      chk("t1_lat",  128'(out_log[0].t - acc_log[0].t), 128'(2));
    end

    // Zero operand then operand one.
    acc_log.delete(); out_log.delete();
    io_in_valid = 4'b0001;
    set_op(0, 128'd0);
    step();
    set_op(0, 128'd1);
    step();
    drain();
    chk("t2_count", 128'(out_log.size()), 128'(2));
    if (out_log.size() >= 2) begin
      chk("t2_clz0",  128'(out_log[0].clz),  128'(127));
      chk("t2_zero0", 128'(out_log[0].zero), 128'(1));
      chk("t2_norm0", out_log[0].norm, 128'd0);
      chk("t2_clz1",  128'(out_log[1].clz),  128'(127));
      chk("t2_zero1", 128'(out_log[1].zero), 128'(0));
      chk("t2_norm1", out_log[1].norm, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
    end

    // Round-robin rotation with everyone valid, starting from reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    acc_log.delete(); out_log.delete();
    for (int i = 0; i < NREQ; i++) set_op(i, 128'h8000_0000_0000_0000_0000_0000_0000_0000 >> i);
    io_in_valid = '1;
    repeat (8) step();
    drain();
    chk("t3_acc",  128'(acc_log.size()), 128'(8));
    chk("t3_outs", 128'(out_log.size()), 128'(8));
    if (acc_log.size() >= 8 && out_log.size() >= 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("t3_grant", 128'(acc_log[k].id), 128'(k % 4));
        chk("t3_clz",   128'(out_log[k].clz), 128'(k % 4));
        chk("t3_rate",  128'(out_log[k].t - out_log[0].t), 128'(k));
      end
    end

    // Backpressure: only two operands fit while the consumer stalls.
    acc_log.delete(); out_log.delete();
    io_out_ready = 1'b0;
    io_in_valid  = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      set_op(1, 128'd1 << (120 - k));
      step();
    end
    chk("t4_acc", 128'(acc_log.size()), 128'(2));
    drain();
    chk("t4_outs", 128'(out_log.size()), 128'(2));
    if (out_log.size() >= 2) begin
      chk("t4_id0",  128'(out_log[0].id),  128'(1));
      chk("t4_clz0", 128'(out_log[0].clz), 128'(7));
      chk("t4_id1",  128'(out_log[1].id),  128'(1));
      chk("t4_clz1", 128'(out_log[1].clz), 128'(8));
    end

    // Reset with both stages full flushes them.
    io_out_ready = 1'b0;
    io_in_valid  = 4'b0001;
    set_op(0, 128'h1234);
    repeat (2) step();
    step();
    chk("t5_full", 128'(io_out_valid), 128'(1));
    io_in_valid = 4'b1001;
    reset = 1'b1;
    acc_log.delete(); out_log.delete();
    step();
    chk("t5_flush", 128'(io_out_valid), 128'(0));
    chk("t5_rdy",   128'(io_in_ready),  128'(0));
    reset = 1'b0;
    io_out_ready = 1'b1;
    step();
    chk("t5_acc", 128'(acc_log.size()), 128'(1));
    if (acc_log.size() >= 1) chk("t5_first", 128'(acc_log[0].id), 128'(0));
    drain();
    chk("t5_outs", 128'(out_log.size()), 128'(1));

    // Pointer must hold while a stall blocks the handshake.
    acc_log.delete(); out_log.delete();
    io_out_ready = 1'b0;
    io_in_valid  = 4'b0001;
    repeat (2) step();
    io_in_valid = 4'b0010;
    repeat (3) step();
    chk("t6_blocked", 128'(acc_log.size()), 128'(2));
    io_in_valid  = 4'b0011;
    io_out_ready = 1'b1;
    step();
    chk("t6_acc", 128'(acc_log.size()), 128'(3));
    if (acc_log.size() >= 3) chk("t6_grant", 128'(acc_log[2].id), 128'(1));
    drain();

    // Randomized traffic with occasional stalls and resets.
    for (int c = 0; c < 3000; c++) begin
      io_in_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) set_op(i, rnd_op());
      io_out_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    drain();
    chk("final_empty", 128'(mq.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
